// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the request, decode and status inputs of the instruction-phase
// sequencer with its phase strobes and PC-control outputs.
//   slave  : the sequencer itself (consumes requests, drives strobes/selects)
//   master : the surrounding core / testbench that drives requests.
// Inputs to sequencer : INT0_REQ, INT1_REQ, INT_EN, RETI, STALL
// Outputs of sequencer: FETCH, DECODE, EXECUTE, COMMIT, PC_NEXTX[2:0],
//                       PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK,
//                       IN_SERVICE[1:0]
interface pc_sequencer_if;
    logic       INT0_REQ;
    logic       INT1_REQ;
    logic       INT_EN;
    logic       RETI;
    logic       STALL;
    logic       FETCH;
    logic       DECODE;
    logic       EXECUTE;
    logic       COMMIT;
    logic [2:0] PC_NEXTX;
    logic       PC_LD_INT0X;
    logic       PC_LD_INT1X;
    logic       INT0_ACK;
    logic       INT1_ACK;
    logic [1:0] IN_SERVICE;

    modport slave (
        input  INT0_REQ, INT1_REQ, INT_EN, RETI, STALL,
        output FETCH, DECODE, EXECUTE, COMMIT, PC_NEXTX,
               PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK, IN_SERVICE
    );

    modport master (
        output INT0_REQ, INT1_REQ, INT_EN, RETI, STALL,
        input  FETCH, DECODE, EXECUTE, COMMIT, PC_NEXTX,
               PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK, IN_SERVICE
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Instruction-phase sequencer (FETCH->DECODE->EXECUTE->COMMIT ring) and
// two-level interrupt controller for the program counter datapath.
// Ports:
//   CLK    : system clock, rising edge
//   RESET  : asynchronous, active-high reset
//   bus    : pc_sequencer_if.slave (requests in, phase strobes and PC
//            next-address select / return-register loads / acks out)
// Parameter:
//   SYNC_STAGES : depth of the per-request synchroniser (>= 2)
module pc_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_DECODE  = 2'd1,
        PH_EXECUTE = 2'd2,
        PH_COMMIT  = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_TAKE0 = 2'd1,
        ACT_TAKE1 = 2'd2,
        ACT_RET   = 2'd3
    } action_t;

    phase_t     phase_reg;
    action_t    action_reg;
    logic       ret_armed_reg;
    logic [1:0] in_service_reg;

    logic [1:0] req;
    logic [1:0] pending;
    logic [1:0] take_clr;
    logic       is_fetch;

    assign req      = {bus.INT1_REQ, bus.INT0_REQ};
    assign is_fetch = (phase_reg == PH_FETCH);

    // A take clears its pending flag in the FETCH that vectors to the handler.
    assign take_clr[0] = is_fetch && (action_reg == ACT_TAKE0);
    assign take_clr[1] = is_fetch && (action_reg == ACT_TAKE1);

    // Per-request synchroniser, rising-edge detector and pending flag.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   pending_reg;
            logic                   rise;

            assign rise        = sync_reg[SYNC_STAGES-1] & ~prev_reg;
            assign pending[gi] = pending_reg;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    sync_reg    <= '0;
                    prev_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], req[gi]};
                    prev_reg    <= sync_reg[SYNC_STAGES-1];
                    // A new edge in the same cycle as a take-clear wins.
                    pending_reg <= rise | (pending_reg & ~take_clr[gi]);
                end
            end
        end
    endgenerate

    // Phase ring plus the COMMIT decision and the FETCH-time commit of it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_reg      <= PH_FETCH;
            action_reg     <= ACT_NONE;
            ret_armed_reg  <= 1'b0;
            in_service_reg <= 2'b00;
        end else begin
            case (phase_reg)
                PH_FETCH: begin
                    phase_reg  <= PH_DECODE;
                    action_reg <= ACT_NONE;
                    case (action_reg)
                        ACT_TAKE0: in_service_reg[0] <= 1'b1;
                        ACT_TAKE1: in_service_reg[1] <= 1'b1;
                        ACT_RET: begin
                            // INT0 is the inner level whenever both are set.
                            if (in_service_reg[0]) begin
                                in_service_reg[0] <= 1'b0;
                            end else begin
                                in_service_reg[1] <= 1'b0;
                            end
                            ret_armed_reg <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                PH_DECODE: begin
                    phase_reg <= PH_EXECUTE;
                end
                PH_EXECUTE: begin
                    if (bus.RETI) begin
                        ret_armed_reg <= 1'b1;
                    end
                    if (!bus.STALL) begin
                        phase_reg <= PH_COMMIT;
                    end
                end
                PH_COMMIT: begin
                    phase_reg <= PH_FETCH;
                    if (ret_armed_reg && (in_service_reg != 2'b00)) begin
                        action_reg <= ACT_RET;
                    end else begin
                        // A RETI with nothing in service is dropped here.
                        ret_armed_reg <= 1'b0;
                        if (bus.INT_EN && pending[0] && !in_service_reg[0]) begin
                            action_reg <= ACT_TAKE0;
                        end else if (bus.INT_EN && pending[1] && (in_service_reg == 2'b00)) begin
                            action_reg <= ACT_TAKE1;
                        end else begin
                            action_reg <= ACT_NONE;
                        end
                    end
                end
                default: phase_reg <= PH_FETCH;
            endcase
        end
    end

    // FETCH-time controls decoded straight from the latched action.
    logic [2:0] pc_nextx;
    logic       ld_int0, ld_int1, ack0, ack1;

    always_comb begin
        pc_nextx = 3'd0;
        ld_int0  = 1'b0;
        ld_int1  = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        if (is_fetch) begin
            case (action_reg)
                ACT_TAKE0: begin
                    pc_nextx = 3'd1;
                    ld_int0  = 1'b1;
                    ack0     = 1'b1;
                end
                ACT_TAKE1: begin
                    pc_nextx = 3'd2;
                    ld_int1  = 1'b1;
                    ack1     = 1'b1;
                end
                ACT_RET: begin
                    pc_nextx = in_service_reg[0] ? 3'd3 : 3'd4;
                end
                default: pc_nextx = 3'd0;
            endcase
        end
    end

    assign bus.FETCH       = is_fetch;
    assign bus.DECODE      = (phase_reg == PH_DECODE);
    assign bus.EXECUTE     = (phase_reg == PH_EXECUTE);
    assign bus.COMMIT      = (phase_reg == PH_COMMIT);
    assign bus.PC_NEXTX    = pc_nextx;
    assign bus.PC_LD_INT0X = ld_int0;
    assign bus.PC_LD_INT1X = ld_int1;
    assign bus.INT0_ACK    = ack0;
    assign bus.INT1_ACK    = ack1;
    assign bus.IN_SERVICE  = in_service_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer: phase ring, request latency, nested
// INT0-over-INT1 entry/return, simultaneous requests, stalled RETI,
// spurious RETI, INT_EN gating and reset during a take.
module tb_pc_sequencer;

    logic CLK;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.SYNC_STAGES(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic int phases();
        return int'({bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT});
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance until the one-hot phase index idx is current (0=F..3=C).
    task automatic goto_phase(input int idx);
        int exp;
        exp = 8 >> idx;
        for (int i = 0; i < 20 && phases() != exp; i++) tick();
        if (phases() != exp) check_val("timeout_phase", phases(), exp);
    endtask

    task automatic next_fetch();
        tick();
        goto_phase(0);
    endtask

    // RETI for one EXECUTE cycle, then run to the FETCH that reflects it.
    task automatic do_reti();
        goto_phase(2);
        bus.RETI = 1'b1;
        tick();
        bus.RETI = 1'b0;
        goto_phase(0);
    endtask

    initial begin
        int n;
        RESET        = 1'b1;
        bus.INT0_REQ = 1'b0;
        bus.INT1_REQ = 1'b0;
        bus.INT_EN   = 1'b0;
        bus.RETI     = 1'b0;
        bus.STALL    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_phase", phases(), 8);
        check_val("rst_nextx", int'(bus.PC_NEXTX), 0);
        check_val("rst_insvc", int'(bus.IN_SERVICE), 0);
        check_val("rst_ld", int'({bus.PC_LD_INT0X, bus.PC_LD_INT1X, bus.INT0_ACK, bus.INT1_ACK}), 0);
        RESET = 1'b0;

        // Idle ring: F,D,E,C three times.
        for (int i = 0; i < 12; i++) begin
            check_val($sformatf("ring%0d", i), phases(), 8 >> (i % 4));
            check_val($sformatf("ring_nx%0d", i), int'(bus.PC_NEXTX), 0);
            tick();
        end
        check_val("ring_insvc", int'(bus.IN_SERVICE), 0);

        // INT1 edge at FETCH: pending after 3 edges, taken in next FETCH.
        bus.INT_EN   = 1'b1;
        bus.INT1_REQ = 1'b1;
        repeat (4) tick();
        check_val("take1_fetch", phases(), 8);
        check_val("take1_nextx", int'(bus.PC_NEXTX), 2);
        check_val("take1_ld", int'(bus.PC_LD_INT1X), 1);
        check_val("take1_ack", int'(bus.INT1_ACK), 1);
        check_val("take1_ack0", int'(bus.INT0_ACK), 0);
        bus.INT1_REQ = 1'b0;
        tick();
        check_val("take1_insvc", int'(bus.IN_SERVICE), 2);
        check_val("take1_ack_off", int'(bus.INT1_ACK), 0);

        // INT0 preempts the INT1 handler; then two nested returns.
        bus.INT0_REQ = 1'b1;
        next_fetch();
        check_val("pre0_none", int'(bus.PC_NEXTX), 0);
        next_fetch();
        check_val("take0_nextx", int'(bus.PC_NEXTX), 1);
        check_val("take0_ack", int'(bus.INT0_ACK), 1);
        check_val("take0_ld", int'(bus.PC_LD_INT0X), 1);
        bus.INT0_REQ = 1'b0;
        tick();
        check_val("nest_insvc", int'(bus.IN_SERVICE), 3);
        do_reti();
        check_val("ret0_nextx", int'(bus.PC_NEXTX), 3);
        check_val("ret0_ld", int'(bus.PC_LD_INT0X), 0);
        tick();
        check_val("ret0_insvc", int'(bus.IN_SERVICE), 2);
        do_reti();
        check_val("ret1_nextx", int'(bus.PC_NEXTX), 4);
        tick();
        check_val("ret1_insvc", int'(bus.IN_SERVICE), 0);

        // Simultaneous INT0/INT1 edges: INT0 first, INT1 after its return.
        bus.INT0_REQ = 1'b1;
        bus.INT1_REQ = 1'b1;
        next_fetch();
        check_val("both_none", int'(bus.PC_NEXTX), 0);
        next_fetch();
        check_val("both_take0", int'(bus.PC_NEXTX), 1);
        bus.INT0_REQ = 1'b0;
        bus.INT1_REQ = 1'b0;
        next_fetch();
        check_val("both_blk1", int'(bus.PC_NEXTX), 0);
        check_val("both_insvc", int'(bus.IN_SERVICE), 1);
        do_reti();
        check_val("both_ret0", int'(bus.PC_NEXTX), 3);
        next_fetch();
        check_val("both_take1", int'(bus.PC_NEXTX), 2);
        do_reti();
        check_val("both_ret1", int'(bus.PC_NEXTX), 4);
        tick();
        check_val("both_insvc0", int'(bus.IN_SERVICE), 0);

        // Enter INT0, re-request INT0 inside it, then stalled RETI.
        bus.INT0_REQ = 1'b1;
        next_fetch();
        next_fetch();
        check_val("st_take0", int'(bus.PC_NEXTX), 1);
        bus.INT0_REQ = 1'b0;
        next_fetch();
        check_val("st_inh_none", int'(bus.PC_NEXTX), 0);
        bus.INT0_REQ = 1'b1;
        n = 0;
        tick(); n++;
        tick(); n++;
        check_val("st_e1", phases(), 2);
        bus.RETI  = 1'b1;
        bus.STALL = 1'b1;
        tick(); n++;
        bus.RETI = 1'b0;
        check_val("st_e2", phases(), 2);
        tick(); n++;
        check_val("st_e3", phases(), 2);
        tick(); n++;
        check_val("st_e4", phases(), 2);
        bus.STALL = 1'b0;
        for (int i = 0; i < 10 && !bus.FETCH; i++) begin
            tick(); n++;
        end
        check_val("st_len", n, 7);
        check_val("st_ret_nextx", int'(bus.PC_NEXTX), 3);
        check_val("st_ret_ack", int'(bus.INT0_ACK), 0);
        next_fetch();
        check_val("st_reenter", int'(bus.PC_NEXTX), 1);
        bus.INT0_REQ = 1'b0;
        tick();
        check_val("st_insvc", int'(bus.IN_SERVICE), 1);
        do_reti();
        check_val("st_ret2", int'(bus.PC_NEXTX), 3);
        tick();
        check_val("st_insvc0", int'(bus.IN_SERVICE), 0);

        // Spurious RETI with nothing in service.
        do_reti();
        check_val("spur_nextx", int'(bus.PC_NEXTX), 0);
        next_fetch();
        check_val("spur_after", int'(bus.PC_NEXTX), 0);

        // INT_EN=0 blocks the take for 5 instructions.
        bus.INT_EN   = 1'b0;
        bus.INT0_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_fetch();
            check_val($sformatf("gate%0d", i), int'(bus.PC_NEXTX), 0);
        end
        bus.INT_EN = 1'b1;
        next_fetch();
        check_val("gate_take", int'(bus.PC_NEXTX), 1);
        check_val("gate_ack", int'(bus.INT0_ACK), 1);

        // Reset in the middle of that TAKE0 FETCH.
        RESET        = 1'b1;
        bus.INT0_REQ = 1'b0;
        #1;
        check_val("rr_nextx", int'(bus.PC_NEXTX), 0);
        check_val("rr_ack", int'(bus.INT0_ACK), 0);
        check_val("rr_ld", int'(bus.PC_LD_INT0X), 0);
        check_val("rr_phase", phases(), 8);
        tick();
        RESET = 1'b0;
        check_val("rr_insvc", int'(bus.IN_SERVICE), 0);
        check_val("rr_phase2", phases(), 8);
        next_fetch();
        check_val("rr_nopend1", int'(bus.PC_NEXTX), 0);
        next_fetch();
        check_val("rr_nopend2", int'(bus.PC_NEXTX), 0);
        check_val("rr_insvc2", int'(bus.IN_SERVICE), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
